// File: rtl/apb_master_bridge_if.sv
// Command, response and APB completer signals of the APB master bridge.
// Pure wiring; no storage or latency of its own.
// Backpressure: cmd_ready / rsp_ready handshakes, Pready stretches APB ACCESS.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] Paddr;
    logic              Pwrite;
    logic [DATA_W-1:0] Pwdata;
    logic              Pselx;
    logic              Penable;
    logic              Pready;
    logic              Pslverr;
    logic [DATA_W-1:0] Prdata;

    logic              busy;

    // Bridge view: it is the APB requester and the command consumer.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  Pready, Pslverr, Prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output Paddr, Pwrite, Pwdata, Pselx, Penable, busy
    );

    // Environment view: command producer, response consumer, APB completer.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output Pready, Pslverr, Prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Paddr, Pwrite, Pwdata, Pselx, Penable, busy
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Command-to-APB bridge: 2-deep command FIFO feeding an IDLE/SETUP/ACCESS/RESP FSM.
// Latency: response valid 3 edges after the accepting edge with zero wait states.
// Backpressure: cmd_ready drops when the FIFO is full; RESP holds until rsp_ready.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 Pclk,
    input  logic                 Prst,
    apb_master_bridge_if.master  bus
);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    cmd_t              fifo_mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              live;
    cmd_t              xfer;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic push;
    logic pop;
    logic fifo_nonempty;
    cmd_t cmd_in;
    cmd_t head;

    assign cmd_in        = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    assign head          = fifo_mem[rd_ptr];
    assign fifo_nonempty = (count != 2'd0);

    // live is low through reset so cmd_ready stays low until the first cycle after release.
    assign bus.cmd_ready = live && (count != 2'd2);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = fifo_nonempty &&
                           ((state == IDLE) || ((state == RESP) && bus.rsp_ready));

    // APB strobes and response valid are pure decodes of the registered state.
    assign bus.Pselx     = (state == SETUP) || (state == ACCESS);
    assign bus.Penable   = (state == ACCESS);
    assign bus.rsp_valid = (state == RESP);
    assign bus.Paddr     = xfer.addr;
    assign bus.Pwrite    = xfer.write;
    assign bus.Pwdata    = xfer.wdata;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = (state != IDLE) || fifo_nonempty;

    // FIFO storage: payload needs no reset, validity lives in count.
    always_ff @(posedge Pclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge Pclk) begin
        if (Prst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Transfer FSM: loads the transfer registers on pop, times out stalled ACCESS.
    always_ff @(posedge Pclk) begin
        if (Prst) begin
            state    <= IDLE;
            xfer     <= '0;
            wait_cnt <= 8'd0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_nonempty) begin
                        xfer     <= head;
                        wait_cnt <= 8'd0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (bus.Pready) begin
                        rdata_q <= xfer.write ? '0 : bus.Prdata;
                        err_q   <= bus.Pslverr;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        // This stalled cycle brings the count up to TIMEOUT.
                        if (wait_cnt == TIMEOUT_LAST) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        if (fifo_nonempty) begin
                            xfer     <= head;
                            wait_cnt <= 8'd0;
                            state    <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a scoreboard of expected responses.
// A negedge process models the APB completer and checks each consumed response.
// Wait states, slave error and read data come from bench-owned configuration.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic clk;
    logic rst;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .Pclk (clk),
        .Prst (rst),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sb [$];

    int checks   = 0;
    int failures = 0;

    // Completer configuration, held constant while commands are outstanding.
    int          cfg_wait  = 0;
    logic        cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    int          acc_cnt   = 0;
    int          resp_cnt  = 0;
    int          flushed   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one command; record its expected response before it can complete.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   guard;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_write = w;
        ifc.cmd_addr  = a;
        ifc.cmd_wdata = d;
        guard = 0;
        while (ifc.cmd_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("cmd_accept_timeout", ifc.cmd_ready, 1'b1);
        e.write = w;
        e.addr  = a;
        e.wdata = d;
        if (cfg_wait >= TO) begin
            e.acc   = TO;
            e.err   = 1'b1;
            e.rdata = 32'h0;
        end else begin
            e.acc   = cfg_wait + 1;
            e.err   = cfg_err;
            e.rdata = w ? 32'h0 : cfg_rdata;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        acc_cnt++;
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((resp_cnt + flushed) != acc_cnt && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(resp_cnt + flushed), 32'(acc_cnt));
        @(negedge clk);
    endtask

    // APB completer model plus response monitor, both working at the negedge.
    int          m_acc   = 0;
    int          m_setup = 0;
    logic [31:0] m_addr  = 32'h0;
    logic        m_stable = 1'b1;
    logic        m_expect_setup = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            m_acc          = 0;
            m_setup        = 0;
            m_stable       = 1'b1;
            m_expect_setup = 1'b0;
            ifc.Pready     = 1'b0;
            ifc.Pslverr    = 1'b0;
            ifc.Prdata     = 32'h0;
        end else begin
            if (m_expect_setup) begin
                chk("resp_to_setup_no_idle", {30'h0, ifc.Pselx, ifc.Penable}, 32'h2);
                m_expect_setup = 1'b0;
            end
            if (ifc.Pselx && !ifc.Penable) begin
                m_setup++;
                m_acc    = 0;
                m_addr   = ifc.Paddr;
                m_stable = 1'b1;
                ifc.Pready = 1'b0;
            end else if (ifc.Pselx && ifc.Penable) begin
                m_acc++;
                if (ifc.Paddr !== m_addr) m_stable = 1'b0;
                if (m_acc > cfg_wait) begin
                    ifc.Pready  = 1'b1;
                    ifc.Pslverr = cfg_err;
                    ifc.Prdata  = cfg_rdata;
                end else begin
                    // Garbage on stalled cycles must be ignored by the bridge.
                    ifc.Pready  = 1'b0;
                    ifc.Pslverr = 1'b1;
                    ifc.Prdata  = ~cfg_rdata;
                end
            end else begin
                ifc.Pready  = 1'b0;
                ifc.Pslverr = 1'b0;
            end
            if (ifc.rsp_valid && ifc.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", {31'h0, ifc.rsp_valid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", ifc.rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, ifc.rsp_err}, {31'h0, e.err});
                    chk("access_cycles", 32'(m_acc), 32'(e.acc));
                    chk("setup_cycles", 32'(m_setup), 32'h1);
                    chk("paddr_stable", {31'h0, m_stable}, 32'h1);
                    chk("paddr", ifc.Paddr, e.addr);
                    chk("pwrite", {31'h0, ifc.Pwrite}, {31'h0, e.write});
                    chk("pwdata", ifc.Pwdata, e.wdata);
                    chk("psel_in_resp", {30'h0, ifc.Pselx, ifc.Penable}, 32'h0);
                end
                resp_cnt++;
                m_setup = 0;
                if (acc_cnt - resp_cnt - flushed > 0) m_expect_setup = 1'b1;
            end
        end
    end

    initial begin
        int lat;
        int seen;

        rst           = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_write = 1'b0;
        ifc.cmd_addr  = 32'h0;
        ifc.cmd_wdata = 32'h0;
        ifc.rsp_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'h0, ifc.cmd_ready}, 32'h0);
        chk("rst_psel", {30'h0, ifc.Pselx, ifc.Penable}, 32'h0);
        chk("rst_pwrite", {31'h0, ifc.Pwrite}, 32'h0);
        chk("rst_paddr", ifc.Paddr, 32'h0);
        chk("rst_pwdata", ifc.Pwdata, 32'h0);
        chk("rst_rsp_valid", {31'h0, ifc.rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", ifc.rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, ifc.rsp_err}, 32'h0);
        chk("rst_busy", {31'h0, ifc.busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_release", {31'h0, ifc.cmd_ready}, 32'h1);

        // Zero-wait write with latency measured from the accepting edge.
        cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = 32'h1111_2222;
        send(1'b1, 32'h04, 32'hDEAD_BEEF);
        lat = 0;
        while (ifc.rsp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("min_latency", 32'(lat), 32'd3);
        drain();

        // Read with two wait states.
        cfg_wait = 2; cfg_rdata = 32'hDEAD_BEEF;
        send(1'b0, 32'h04, 32'h0);
        drain();

        // Back-to-back commands: FIFO fills while the first transfer runs.
        cfg_wait = 0; cfg_rdata = 32'hCAFE_0001;
        send(1'b1, 32'h100, 32'h0000_00A1);
        send(1'b0, 32'h104, 32'h0000_00A2);
        send(1'b1, 32'h108, 32'h0000_00A3);
        chk("cmd_ready_full", {31'h0, ifc.cmd_ready}, 32'h0);
        send(1'b0, 32'h10C, 32'h0000_00A4);
        drain();

        // Timeout with Pready held low.
        cfg_wait = 1000; cfg_rdata = 32'h5555_AAAA;
        send(1'b0, 32'h20, 32'h0);
        drain();

        // Slave error on a read still returns the read data.
        cfg_wait = 1; cfg_err = 1'b1; cfg_rdata = 32'h1234_5678;
        send(1'b0, 32'h30, 32'h0);
        drain();
        cfg_err = 1'b0;

        // Response held under rsp_ready backpressure.
        ifc.rsp_ready = 1'b0;
        cfg_wait = 0;
        send(1'b1, 32'h40, 32'h0BAD_F00D);
        lat = 0;
        while (ifc.rsp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        repeat (4) @(negedge clk);
        chk("rsp_held_valid", {31'h0, ifc.rsp_valid}, 32'h1);
        chk("rsp_held_busy", {31'h0, ifc.busy}, 32'h1);
        ifc.rsp_ready = 1'b1;
        drain();

        // Reset during ACCESS with one command queued behind it.
        cfg_wait = 1000;
        send(1'b0, 32'h50, 32'h0);
        send(1'b1, 32'h54, 32'h0000_0054);
        lat = 0;
        while (ifc.Penable !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("reached_access", {31'h0, ifc.Penable}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        flushed = acc_cnt - resp_cnt;
        @(negedge clk);
        chk("midrst_psel", {30'h0, ifc.Pselx, ifc.Penable}, 32'h0);
        chk("midrst_busy", {31'h0, ifc.busy}, 32'h0);
        chk("midrst_cmd_ready", {31'h0, ifc.cmd_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (ifc.rsp_valid === 1'b1) seen++;
        end
        chk("no_rsp_after_rst", 32'(seen), 32'h0);

        // Recovery: a fresh read completes normally.
        cfg_wait = 0; cfg_rdata = 32'hA5A5_5A5A;
        send(1'b0, 32'h10, 32'h0);
        drain();
        chk("final_idle_busy", {31'h0, ifc.busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
